// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller.
//   - FSM state encodings (2-bit): ST_RUN, ST_LU_STALL, ST_MEM_WAIT.
//   - REG_ZERO: architectural zero register. It never creates a dependency.
//   - CTRL_SIG_W / MEMREAD_BIT: layout of the 9-bit ID/EX controlSig bundle.
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ILLEGAL  = 2'd3
    } hz_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         CTRL_SIG_W  = 9;
    localparam int         MEMREAD_BIT = 5;

    // Extracts memRead from a full ID/EX controlSig word.
    function automatic logic ctrl_mem_read(input logic [CTRL_SIG_W-1:0] ctrl_sig);
        return ctrl_sig[MEMREAD_BIT];
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector.
// Ports:
//   id_rs, id_rt   : source register fields of the instruction in ID
//   id_uses_rt     : ID instruction reads rt as a source
//   ex_mem_read    : instruction in EX is a load
//   ex_rt          : load destination register in EX
//   load_use       : ID needs the loaded value before it is available
// -----------------------------------------------------------------------------
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt & (ex_rt == id_rt);

    // A load to the zero register never produces a value worth waiting for.
    assign load_use = ex_mem_read & (ex_rt != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard controller for the PC, IF/ID and ID/EX registers of a 5-stage
// pipeline. Resolves load-use hazards, data-cache misses and taken branches
// (priority: Rst > miss > branchTaken > loadUse). The FSM is posedge-clocked;
// the pipeline registers sample the combinational controls on the next negedge.
//
// Ports:
//   Clk, Rst         : clock (posedge), synchronous active-high reset
//   idRs, idRt,
//   idUsesRt         : source operands of the instruction in ID
//   exMemRead, exRt  : load indication / destination of the instruction in EX
//   branchTaken      : branch/jump resolved taken in EX
//   memReq, cacheHit : data-cache access in MEM and its hit status
//   pcWrite          : PC load enable
//   ifIdWrite        : IF/ID load enable
//   idExHit          : ID/EX load enable
//   idExBubble       : forces controlSig=0 into ID/EX
//   ifIdFlush        : clears IF/ID to a NOP
//   missTimeout      : sticky flag, miss lasted MISS_TIMEOUT MEM_WAIT cycles
//   stallCycles      : (HAZARD_STALL_CNT_EN only) saturating count of cycles
//                      with pcWrite=0
//   ctrlState        : current FSM state (debug)
//
// Build option: define HAZARD_STALL_CNT_EN to add the stallCycles counter.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MISS_TIMEOUT    = 64,
    parameter int CNT_W           = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             exMemRead,
    input  logic [4:0]       exRt,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             cacheHit,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             idExHit,
    output logic             idExBubble,
    output logic             ifIdFlush,
    output logic             missTimeout,
`ifdef HAZARD_STALL_CNT_EN
    output logic [CNT_W-1:0] stallCycles,
`endif
    output logic [1:0]       ctrlState
);

    if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 15) begin : g_bad_lu
        $error("LU_STALL_CYCLES must be in 1..15");
    end
    if (MISS_TIMEOUT < 0) begin : g_bad_mt
        $error("MISS_TIMEOUT must be non-negative");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    localparam logic [3:0]  LU_LOAD = 4'(LU_STALL_CYCLES - 1);
    localparam logic [31:0] MT_LAST = (MISS_TIMEOUT == 0) ? 32'd0 : 32'(MISS_TIMEOUT - 1);

    hz_state_e   state_q, state_d;
    logic [3:0]  lu_cnt_q, lu_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        timeout_q, timeout_d;

    logic load_use;
    logic miss;

    logic pc_write;
    logic if_id_write;
    logic id_ex_hit;
    logic id_ex_bubble;
    logic if_id_flush;

    load_use_detect u_load_use (
        .id_rs       (idRs),
        .id_rt       (idRt),
        .id_uses_rt  (idUsesRt),
        .ex_mem_read (exMemRead),
        .ex_rt       (exRt),
        .load_use    (load_use)
    );

    assign miss = memReq & ~cacheHit;

    always_comb begin
        state_d      = state_q;
        lu_cnt_d     = lu_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        timeout_d    = timeout_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_hit    = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;

        case (state_q)
            ST_RUN, ST_LU_STALL: begin
                if (miss) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_hit    = 1'b0;
                    state_d      = ST_MEM_WAIT;
                    miss_cnt_d   = 32'd0;
                end else if (branchTaken) begin
                    // Squash the wrong-path instructions in IF/ID and ID/EX.
                    id_ex_bubble = 1'b1;
                    if_id_flush  = 1'b1;
                    state_d      = ST_RUN;
                end else if (state_q == ST_LU_STALL) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    lu_cnt_d     = lu_cnt_q - 4'd1;
                    // Counter hitting zero ends the stall this cycle.
                    state_d      = (lu_cnt_q == 4'd1) ? ST_RUN : ST_LU_STALL;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    lu_cnt_d     = LU_LOAD;
                    state_d      = (LU_LOAD == 4'd0) ? ST_RUN : ST_LU_STALL;
                end
            end
            ST_MEM_WAIT: begin
                // Full freeze: ID/EX keeps its content, branches are ignored.
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_hit   = 1'b0;
                if (miss_cnt_q != 32'hFFFF_FFFF) begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                end
                if (cacheHit) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_hit   = 1'b0;
                state_d     = ST_RUN;
            end
        endcase

        // Raise the flag as the count reaches its limit so it is visible
        // during the MISS_TIMEOUT-th MEM_WAIT cycle.
        if (MISS_TIMEOUT != 0 && state_d == ST_MEM_WAIT && miss_cnt_d == MT_LAST) begin
            timeout_d = 1'b1;
        end

        if (Rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_hit    = 1'b1;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_RUN;
            lu_cnt_q   <= 4'd0;
            miss_cnt_q <= 32'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;
`endif

    assign pcWrite     = pc_write;
    assign ifIdWrite   = if_id_write;
    assign idExHit     = id_ex_hit;
    assign idExBubble  = id_ex_bubble;
    assign ifIdFlush   = if_id_flush;
    assign missTimeout = timeout_q;
    assign ctrlState   = state_q;

endmodule
